// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - RV32I memory-stage load/store unit with ready/valid data-memory port
module mem_stage_lsu #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_store_data,
  input  logic [4:0]  ex_rd,
  input  logic [2:0]  ex_funct3,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic        ex_reg_write,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ready,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] wb_data_out,
  output logic [4:0]  instruction_rd_out,
  output logic        register_write_enable_out,
  output logic        mem_stall,
  output logic        misaligned_out,
  output logic        bus_error_out
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        addr_lo_q, addr_lo_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [4:0]        rd_q, rd_d;
  logic              reg_write_q, reg_write_d;
  logic              is_load_q, is_load_d;
  logic              err_q, err_d;
  logic [31:0]       rbuf_q, rbuf_d;

  logic              mem_op;
  logic              is_store;
  logic              align_ok;
  logic              size_ok;
  logic              legal;
  logic [31:0]       st_wdata;
  logic [3:0]        st_wstrb;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [31:0]       ld_data;

  // Classify the EX/MEM instruction and check access size and alignment
  always_comb begin
    mem_op   = ex_valid & (ex_mem_read | ex_mem_write);
    is_store = ex_mem_write;
    case (ex_funct3[1:0])
      2'b00:   align_ok = 1'b1;
      2'b01:   align_ok = ~ex_alu_result[0];
      2'b10:   align_ok = (ex_alu_result[1:0] == 2'b00);
      default: align_ok = 1'b0;
    endcase
    if (is_store) begin
      size_ok = (ex_funct3[2] == 1'b0) && (ex_funct3[1:0] != 2'b11);
    end else begin
      size_ok = (ex_funct3 != 3'b011) && (ex_funct3[2:1] != 2'b11);
    end
    legal = align_ok & size_ok;
  end

  // Replicate store data across the word and place the byte strobes
  always_comb begin
    case (ex_funct3[1:0])
      2'b00: begin
        st_wdata = {4{ex_store_data[7:0]}};
        st_wstrb = 4'b0001 << ex_alu_result[1:0];
      end
      2'b01: begin
        st_wdata = {2{ex_store_data[15:0]}};
        st_wstrb = 4'b0011 << {ex_alu_result[1], 1'b0};
      end
      default: begin
        st_wdata = ex_store_data;
        st_wstrb = 4'b1111;
      end
    endcase
  end

  // Extract and extend the loaded byte/half/word from the captured response
  always_comb begin
    ld_byte = rbuf_q[{addr_lo_q, 3'b000} +: 8];
    ld_half = addr_lo_q[1] ? rbuf_q[31:16] : rbuf_q[15:0];
    case (funct3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'h0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'h0, ld_half};
      default: ld_data = rbuf_q;
    endcase
  end

  // Access sequencing: next state, latches and all outputs
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_lo_d   = addr_lo_q;
    funct3_d    = funct3_q;
    rd_d        = rd_q;
    reg_write_d = reg_write_q;
    is_load_d   = is_load_q;
    err_d       = err_q;
    rbuf_d      = rbuf_q;

    dmem_req                  = 1'b0;
    dmem_we                   = 1'b0;
    dmem_addr                 = 32'h0;
    dmem_wdata                = 32'h0;
    dmem_wstrb                = 4'h0;
    wb_data_out               = 32'h0;
    instruction_rd_out        = 5'h0;
    register_write_enable_out = 1'b0;
    mem_stall                 = 1'b0;
    misaligned_out            = 1'b0;
    bus_error_out             = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ex_valid && !mem_op) begin
          wb_data_out               = ex_alu_result;
          instruction_rd_out        = ex_rd;
          register_write_enable_out = ex_reg_write;
        end else if (mem_op && !legal) begin
          misaligned_out = 1'b1;
        end else if (mem_op) begin
          dmem_req    = 1'b1;
          dmem_we     = is_store;
          dmem_addr   = {ex_alu_result[31:2], 2'b00};
          dmem_wdata  = is_store ? st_wdata : 32'h0;
          dmem_wstrb  = is_store ? st_wstrb : 4'h0;
          mem_stall   = 1'b1;
          addr_lo_d   = ex_alu_result[1:0];
          funct3_d    = ex_funct3;
          rd_d        = ex_rd;
          reg_write_d = ex_reg_write;
          is_load_d   = ~is_store;
          cnt_d       = '0;
          state_d     = dmem_ready ? S_WAIT : S_REQ;
        end
      end
      S_REQ: begin
        // EX/MEM is frozen, so the ex_* inputs still describe this access
        dmem_req   = 1'b1;
        dmem_we    = is_store;
        dmem_addr  = {ex_alu_result[31:2], 2'b00};
        dmem_wdata = is_store ? st_wdata : 32'h0;
        dmem_wstrb = is_store ? st_wstrb : 4'h0;
        mem_stall  = 1'b1;
        if (dmem_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        mem_stall = 1'b1;
        cnt_d     = cnt_q + CNT_W'(1);
        if (dmem_rvalid) begin
          rbuf_d  = dmem_rdata;
          cnt_d   = '0;
          state_d = S_DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        instruction_rd_out = rd_q;
        if (is_load_q) begin
          wb_data_out               = ld_data;
          register_write_enable_out = reg_write_q & ~err_q;
        end
        bus_error_out = err_q;
        err_d         = 1'b0;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and latch registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      addr_lo_q   <= 2'b00;
      funct3_q    <= 3'b000;
      rd_q        <= 5'h0;
      reg_write_q <= 1'b0;
      is_load_q   <= 1'b0;
      err_q       <= 1'b0;
      rbuf_q      <= 32'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_lo_q   <= addr_lo_d;
      funct3_q    <= funct3_d;
      rd_q        <= rd_d;
      reg_write_q <= reg_write_d;
      is_load_q   <= is_load_d;
      err_q       <= err_d;
      rbuf_q      <= rbuf_d;
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - self-checking bench for mem_stage_lsu
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_rd;
  logic [2:0]  ex_funct3;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_reg_write;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ready;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic [31:0] wb_data_out;
  logic [4:0]  instruction_rd_out;
  logic        register_write_enable_out;
  logic        mem_stall;
  logic        misaligned_out;
  logic        bus_error_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage_lsu #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .ex_funct3(ex_funct3), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_ready(dmem_ready),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .wb_data_out(wb_data_out), .instruction_rd_out(instruction_rd_out),
    .register_write_enable_out(register_write_enable_out), .mem_stall(mem_stall),
    .misaligned_out(misaligned_out), .bus_error_out(bus_error_out)
  );

  // Reference model: RV32I access rules in plain arithmetic
  function automatic logic legal_m(input logic st, input logic [2:0] f3, input logic [31:0] a);
    int bytes;
    if (st && f3 > 3'd2) return 1'b0;
    if (!st && (f3 == 3'd3 || f3 > 3'd5)) return 1'b0;
    bytes = 1 << int'(f3 % 3'd4);
    return (a % 32'(bytes)) == 32'd0;
  endfunction

  function automatic logic [31:0] load_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> (8 * (a % 4))) & 32'hFF;
    h = (w >> (16 * ((a % 4) / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'd128) ? b - 32'd256 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] store_data_m(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'd0:    return (d & 32'hFF) * 32'h01010101;
      3'd1:    return (d & 32'hFFFF) * 32'h00010001;
      default: return d;
    endcase
  endfunction

  function automatic logic [3:0] store_strb_m(input logic [2:0] f3, input logic [31:0] a);
    int bytes;
    logic [31:0] m;
    bytes = 1 << int'(f3);
    m = ((32'd1 << bytes) - 32'd1) << (a % 4);
    return m[3:0];
  endfunction

  task automatic set_idle();
    ex_valid      = 1'b0;
    ex_alu_result = 32'h0;
    ex_store_data = 32'h0;
    ex_rd         = 5'h0;
    ex_funct3     = 3'h0;
    ex_mem_read   = 1'b0;
    ex_mem_write  = 1'b0;
    ex_reg_write  = 1'b0;
    dmem_ready    = 1'b0;
    dmem_rvalid   = 1'b0;
    dmem_rdata    = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    set_idle();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if ({dmem_req, dmem_we, mem_stall, register_write_enable_out, misaligned_out, bus_error_out} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000000",
               {dmem_req, dmem_we, mem_stall, register_write_enable_out, misaligned_out, bus_error_out});
    end
    checks++;
    if ({wb_data_out, instruction_rd_out, dmem_addr, dmem_wdata, dmem_wstrb} !== 105'b0) begin
      errors++;
      $display("FAIL reset_data: got wb=%h rd=%h addr=%h wdata=%h wstrb=%h expected all zero",
               wb_data_out, instruction_rd_out, dmem_addr, dmem_wdata, dmem_wstrb);
    end
  endtask

  task automatic test_alu();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      set_idle();
      ex_valid      = 1'b1;
      ex_alu_result = (i == 0) ? 32'h1234 : $urandom;
      ex_rd         = (i == 0) ? 5'd5 : 5'($urandom);
      ex_reg_write  = (i == 0) ? 1'b1 : 1'($urandom);
      ex_funct3     = 3'($urandom);
      ex_store_data = $urandom;
      #1;
      checks++;
      if ({wb_data_out, instruction_rd_out, register_write_enable_out} !== {ex_alu_result, ex_rd, ex_reg_write}) begin
        errors++;
        $display("FAIL alu_pass[%0d]: got wb=%h rd=%0d we=%b expected wb=%h rd=%0d we=%b", i,
                 wb_data_out, instruction_rd_out, register_write_enable_out, ex_alu_result, ex_rd, ex_reg_write);
      end
      checks++;
      if ({mem_stall, dmem_req, misaligned_out} !== 3'b000) begin
        errors++;
        $display("FAIL alu_ctrl[%0d]: got stall/req/mis=%b expected 000", i, {mem_stall, dmem_req, misaligned_out});
      end
    end
  endtask

  task automatic test_load(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] w,
                           input int rdy_dly, input int rv_dly);
    logic [31:0] exp;
    int stalls;
    exp    = load_m(f3, addr, w);
    stalls = 0;
    @(negedge clk);
    set_idle();
    ex_valid      = 1'b1;
    ex_mem_read   = 1'b1;
    ex_alu_result = addr;
    ex_funct3     = f3;
    ex_rd         = 5'($urandom);
    ex_reg_write  = 1'($urandom);
    ex_store_data = $urandom;
    dmem_ready    = (rdy_dly == 0);
    #1;
    if (mem_stall) stalls++;
    checks++;
    if ({dmem_req, dmem_we, dmem_wstrb, dmem_addr} !== {1'b1, 1'b0, 4'h0, addr - (addr % 4)}) begin
      errors++;
      $display("FAIL load_req: got req=%b we=%b strb=%h addr=%h expected 1 0 0 %h",
               dmem_req, dmem_we, dmem_wstrb, dmem_addr, addr - (addr % 4));
    end
    for (int i = 0; i < rdy_dly; i++) begin
      @(negedge clk);
      dmem_ready = (i == rdy_dly - 1);
      #1;
      if (mem_stall) stalls++;
      checks++;
      if ({dmem_req, dmem_addr} !== {1'b1, addr - (addr % 4)}) begin
        errors++;
        $display("FAIL load_req_held: got req=%b addr=%h expected 1 %h", dmem_req, dmem_addr, addr - (addr % 4));
      end
    end
    for (int i = 0; i < rv_dly; i++) begin
      @(negedge clk);
      dmem_ready  = 1'b0;
      dmem_rvalid = (i == rv_dly - 1);
      dmem_rdata  = (i == rv_dly - 1) ? w : $urandom;
      #1;
      if (mem_stall) stalls++;
      if (dmem_req) begin
        checks++;
        errors++;
        $display("FAIL load_wait_req: got req=1 expected 0");
      end
    end
    @(negedge clk);
    dmem_rvalid = 1'b0;
    dmem_rdata  = $urandom;
    #1;
    checks++;
    if (stalls !== 1 + rdy_dly + rv_dly || mem_stall !== 1'b0) begin
      errors++;
      $display("FAIL load_stall_cycles: got %0d (done stall=%b) expected %0d (0)", stalls, mem_stall, 1 + rdy_dly + rv_dly);
    end
    checks++;
    if ({wb_data_out, instruction_rd_out, register_write_enable_out, bus_error_out} !== {exp, ex_rd, ex_reg_write, 1'b0}) begin
      errors++;
      $display("FAIL load_done f3=%0d addr=%h: got wb=%h rd=%0d we=%b err=%b expected wb=%h rd=%0d we=%b err=0",
               f3, addr, wb_data_out, instruction_rd_out, register_write_enable_out, bus_error_out, exp, ex_rd, ex_reg_write);
    end
  endtask

  task automatic test_store(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] d,
                            input int rdy_dly, input int rv_dly);
    logic [31:0] ew;
    logic [3:0]  es;
    int stalls;
    ew     = store_data_m(f3, d);
    es     = store_strb_m(f3, addr);
    stalls = 0;
    @(negedge clk);
    set_idle();
    ex_valid      = 1'b1;
    ex_mem_write  = 1'b1;
    ex_alu_result = addr;
    ex_funct3     = f3;
    ex_store_data = d;
    ex_rd         = 5'($urandom);
    ex_reg_write  = 1'($urandom);
    dmem_ready    = (rdy_dly == 0);
    for (int i = 0; i <= rdy_dly; i++) begin
      if (i > 0) begin
        @(negedge clk);
        dmem_ready = (i == rdy_dly);
      end
      #1;
      if (mem_stall) stalls++;
      checks++;
      if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb} !== {1'b1, 1'b1, addr - (addr % 4), ew, es}) begin
        errors++;
        $display("FAIL store_req[%0d] f3=%0d: got req=%b we=%b addr=%h wdata=%h strb=%b expected 1 1 %h %h %b",
                 i, f3, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb, addr - (addr % 4), ew, es);
      end
    end
    for (int i = 0; i < rv_dly; i++) begin
      @(negedge clk);
      dmem_ready  = 1'b0;
      dmem_rvalid = (i == rv_dly - 1);
      #1;
      if (mem_stall) stalls++;
    end
    @(negedge clk);
    dmem_rvalid = 1'b0;
    #1;
    checks++;
    if ({stalls, mem_stall, register_write_enable_out, bus_error_out} !== {1 + rdy_dly + rv_dly, 3'b000}) begin
      errors++;
      $display("FAIL store_done: got stalls=%0d stall=%b we=%b err=%b expected %0d 0 0 0",
               stalls, mem_stall, register_write_enable_out, bus_error_out, 1 + rdy_dly + rv_dly);
    end
  endtask

  task automatic test_illegal();
    int found;
    found = 0;
    for (int t = 0; t < 300 && found < 8; t++) begin
      logic        st;
      logic [2:0]  f3;
      logic [31:0] a;
      st = (t == 0 || t == 1) ? 1'b0 : 1'($urandom);
      f3 = (t == 0) ? 3'd2 : (t == 1) ? 3'd3 : 3'($urandom);
      a  = (t == 0) ? 32'h101 : (t == 1) ? 32'h100 : $urandom;
      if (!legal_m(st, f3, a)) begin
        found++;
        @(negedge clk);
        set_idle();
        ex_valid      = 1'b1;
        ex_mem_read   = ~st;
        ex_mem_write  = st;
        ex_funct3     = f3;
        ex_alu_result = a;
        ex_reg_write  = 1'b1;
        ex_rd         = 5'($urandom);
        dmem_ready    = 1'b1;
        #1;
        checks++;
        if ({dmem_req, mem_stall, register_write_enable_out, misaligned_out} !== 4'b0001) begin
          errors++;
          $display("FAIL illegal st=%b f3=%0d addr=%h: got req/stall/we/mis=%b expected 0001",
                   st, f3, a, {dmem_req, mem_stall, register_write_enable_out, misaligned_out});
        end
        @(negedge clk);
        set_idle();
        #1;
        checks++;
        if ({dmem_req, mem_stall, misaligned_out} !== 3'b000) begin
          errors++;
          $display("FAIL illegal_after: got req/stall/mis=%b expected 000", {dmem_req, mem_stall, misaligned_out});
        end
      end
    end
    checks++;
    if (found < 2) begin
      errors++;
      $display("FAIL illegal_count: got %0d expected at least 2", found);
    end
  endtask

  task automatic test_timeout();
    int n;
    @(negedge clk);
    set_idle();
    ex_valid      = 1'b1;
    ex_mem_read   = 1'b1;
    ex_funct3     = 3'd2;
    ex_alu_result = 32'h400;
    ex_rd         = 5'd9;
    ex_reg_write  = 1'b1;
    dmem_ready    = 1'b1;
    @(negedge clk);
    dmem_ready = 1'b0;
    n = 0;
    while (n < 40) begin
      #1;
      if (!mem_stall) break;
      n++;
      @(negedge clk);
    end
    checks++;
    if (n !== 16) begin
      errors++;
      $display("FAIL timeout_wait_cycles: got %0d expected 16", n);
    end
    checks++;
    if ({bus_error_out, register_write_enable_out, mem_stall} !== 3'b100) begin
      errors++;
      $display("FAIL timeout_done: got err/we/stall=%b expected 100",
               {bus_error_out, register_write_enable_out, mem_stall});
    end
    @(negedge clk);
    set_idle();
    #1;
    checks++;
    if ({bus_error_out, mem_stall, dmem_req} !== 3'b000) begin
      errors++;
      $display("FAIL timeout_idle: got err/stall/req=%b expected 000", {bus_error_out, mem_stall, dmem_req});
    end
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    set_idle();
    ex_valid      = 1'b1;
    ex_mem_read   = 1'b1;
    ex_funct3     = 3'd2;
    ex_alu_result = 32'h800;
    ex_rd         = 5'd3;
    ex_reg_write  = 1'b1;
    dmem_ready    = 1'b1;
    @(negedge clk);
    dmem_ready = 1'b0;
    #1;
    checks++;
    if ({mem_stall, dmem_req} !== 2'b10) begin
      errors++;
      $display("FAIL midrst_wait: got stall/req=%b expected 10", {mem_stall, dmem_req});
    end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    set_idle();
    #1;
    checks++;
    if ({mem_stall, dmem_req, register_write_enable_out} !== 3'b000) begin
      errors++;
      $display("FAIL midrst_idle: got stall/req/we=%b expected 000", {mem_stall, dmem_req, register_write_enable_out});
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      dmem_rvalid = 1'b1;
      dmem_rdata  = $urandom;
      #1;
      checks++;
      if ({mem_stall, register_write_enable_out, wb_data_out} !== 34'b0) begin
        errors++;
        $display("FAIL midrst_late_rvalid[%0d]: got stall=%b we=%b wb=%h expected 0 0 0",
                 i, mem_stall, register_write_enable_out, wb_data_out);
      end
    end
    @(negedge clk);
    set_idle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    test_load(32'h1002, 3'd1, 32'h8001_7FFF, 0, 1);
    test_store(32'h2001, 3'd0, 32'h0000_00A5, 0, 1);
    @(negedge clk);
    set_idle();
    r             = $urandom;
    ex_valid      = 1'b1;
    ex_alu_result = r;
    ex_rd         = 5'd17;
    ex_reg_write  = 1'b1;
    #1;
    checks++;
    if ({wb_data_out, instruction_rd_out, register_write_enable_out, mem_stall} !== {r, 5'd17, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL b2b_alu: got wb=%h rd=%0d we=%b stall=%b expected %h 17 1 0",
               wb_data_out, instruction_rd_out, register_write_enable_out, mem_stall, r);
    end
    @(negedge clk);
    set_idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [2:0]  f3;
    logic [31:0] a;
    int sz;
    test_reset();
    test_alu();
    test_load(32'h103, 3'd0, 32'h80FF_0000, 0, 1);
    test_load(32'h103, 3'd4, 32'h80FF_0000, 0, 1);
    test_load(32'h204, 3'd2, 32'hDEAD_BEEF, 0, 16);
    for (int i = 0; i < 12; i++) begin
      case ($urandom % 5)
        0: f3 = 3'd0;
        1: f3 = 3'd1;
        2: f3 = 3'd2;
        3: f3 = 3'd4;
        default: f3 = 3'd5;
      endcase
      sz = 1 << int'(f3 % 3'd4);
      a  = $urandom;
      a  = a - (a % 32'(sz));
      test_load(a, f3, $urandom, int'($urandom % 3), 1 + int'($urandom % 3));
    end
    test_store(32'h202, 3'd1, 32'hABCD_1234, 3, 1);
    test_store(32'h301, 3'd0, 32'h1234_56C3, 0, 1);
    test_store(32'h304, 3'd2, 32'hCAFE_F00D, 1, 2);
    for (int i = 0; i < 10; i++) begin
      f3 = 3'($urandom % 3);
      sz = 1 << int'(f3);
      a  = $urandom;
      a  = a - (a % 32'(sz));
      test_store(a, f3, $urandom, int'($urandom % 4), 1 + int'($urandom % 2));
    end
    @(negedge clk);
    set_idle();
    test_illegal();
    test_timeout();
    test_reset_mid_op();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
